pedal_mem_sched: RTL and testbench

//  Scheduler for the pedal's single-port delay/reverb sample SRAM. On each audio sample strobe it writes
//  the dry sample, then issues up to MAX_TAPS delayed-tap reads. It sums the taps with geometric gain decay,

---
 rtl/pedal_mem_sched.sv | 186 ++++++++++++++++++
 tb/tb_pedal_mem_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pedal_mem_sched.sv
// Delay/reverb SRAM scheduler: per sample strobe, write the dry sample, read up to MAX_TAPS taps, emit saturated wet sample.
// Latency: out_valid n+3 cycles after sample_valid (n = active taps, 0 => 3 cycles, dry only).
// Backpressure: none; sample_valid outside IDLE is dropped and flagged on sticky overrun.
// Optional PEDAL_SCHED_STATUS_EN adds busy and overrun_cnt status ports.
module pedal_mem_sched #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int MAX_TAPS = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              record,
  input  logic              delay_reverb,
  input  logic [7:0]        impulses,
  input  logic [7:0]        gain,
  input  logic [ADDR_W-1:0] delay_len,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              overrun
`ifdef PEDAL_SCHED_STATUS_EN
  ,
  output logic              busy,
  output logic [7:0]        overrun_cnt
`endif
);

  localparam int ACC_W = DATA_W + 4;
  localparam int TAP_W = $clog2(MAX_TAPS + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, OUT} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        cfg_dl;
  logic                     cfg_record;
  logic [7:0]               cfg_gain;
  logic [TAP_W-1:0]         n_taps;
  logic [TAP_W-1:0]         tap_cnt;
  logic [7:0]               w_cur;
  logic [7:0]               rd_w;
  logic                     rd_pend;
  logic [DATA_W-1:0]        wdata;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W+8:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic [TAP_W-1:0]         n_sel;
  logic                     accept;

  assign accept = (state == IDLE) && sample_valid;

  // Tap count for the incoming sample: echo mode is always one tap, reverb clamps to MAX_TAPS.
  always_comb begin
    n_sel = TAP_W'(1);
    if (delay_reverb) begin
      if (impulses > 8'(MAX_TAPS)) n_sel = TAP_W'(MAX_TAPS);
      else                         n_sel = TAP_W'(impulses);
    end
  end

  // Weighted tap term from the read issued last cycle, folded into the running sum.
  always_comb begin
    prod    = $signed(mem_rdata) * $signed({1'b0, rd_w});
    term    = ACC_W'(prod >>> 8);
    acc_nxt = acc;
    if (rd_pend) acc_nxt = acc + term;
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and SRAM port drive; the port is idle outside WRITE/READ so one access per cycle at most.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (sample_valid) state_nxt = WRITE;
      WRITE: begin
        mem_en    = cfg_record;
        mem_we    = cfg_record;
        mem_addr  = wr_ptr;
        mem_wdata = wdata;
        state_nxt = (n_taps == '0) ? DRAIN : READ;
      end
      READ: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
        if (tap_cnt == n_taps) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture config at accept, walk tap addresses/weights, accumulate, saturate on DRAIN.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_addr    <= '0;
      cfg_dl     <= '0;
      cfg_record <= 1'b0;
      cfg_gain   <= '0;
      n_taps     <= '0;
      tap_cnt    <= '0;
      w_cur      <= '0;
      rd_w       <= '0;
      rd_pend    <= 1'b0;
      wdata      <= '0;
      acc        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      rd_pend   <= (state == READ);
      out_valid <= (state == DRAIN);
      if (rd_pend) acc <= acc_nxt;
      case (state)
        IDLE: if (sample_valid) begin
          acc        <= ACC_W'($signed(sample_in));
          wdata      <= sample_in;
          cfg_record <= record;
          cfg_gain   <= gain;
          cfg_dl     <= (delay_len == '0) ? ADDR_W'(1) : delay_len;
          n_taps     <= n_sel;
        end
        WRITE: begin
          rd_addr <= wr_ptr - cfg_dl;
          w_cur   <= cfg_gain;
          tap_cnt <= TAP_W'(1);
        end
        READ: begin
          rd_addr <= rd_addr - cfg_dl;
          rd_w    <= w_cur;
          w_cur   <= 8'((16'(w_cur) * 16'(cfg_gain)) >> 8);
          tap_cnt <= tap_cnt + TAP_W'(1);
        end
        DRAIN: begin
          if (acc_nxt > SAT_MAX)      sample_out <= SAT_MAX[DATA_W-1:0];
          else if (acc_nxt < SAT_MIN) sample_out <= SAT_MIN[DATA_W-1:0];
          else                        sample_out <= acc_nxt[DATA_W-1:0];
        end
        OUT: if (cfg_record) wr_ptr <= wr_ptr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky flag for samples that arrive while a sequence is in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                             overrun <= 1'b0;
    else if (sample_valid && state != IDLE)   overrun <= 1'b1;
  end

`ifdef PEDAL_SCHED_STATUS_EN
  assign busy = (state != IDLE);

  // Saturating count of dropped samples.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      overrun_cnt <= '0;
    else if (sample_valid && state != IDLE && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

  // Accepted-sample strobe is only used by the FSM through sample_valid; keep it visible for debug.
  logic unused_ok;
  assign unused_ok = accept;

endmodule

// File: tb/tb_pedal_mem_sched.sv
// Self-checking bench for pedal_mem_sched: SRAM model, reference arithmetic model, output scoreboard.
// Expected outputs and due cycles are queued at each strobe and compared when out_valid fires.
// Bound waits: every wait on the DUT has a cycle budget.
module tb_pedal_mem_sched;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic               record;
  logic               delay_reverb;
  logic [7:0]         impulses;
  logic [7:0]         gain;
  logic [9:0]         delay_len;
  logic               mem_en, mem_we;
  logic [9:0]         mem_addr;
  logic [15:0]        mem_wdata;
  logic [15:0]        mem_rdata;
  logic [15:0]        sample_out;
  logic               out_valid;
  logic               overrun;
`ifdef PEDAL_SCHED_STATUS_EN
  logic               busy;
  logic [7:0]         overrun_cnt;
`endif

  pedal_mem_sched dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .record       (record),
    .delay_reverb (delay_reverb),
    .impulses     (impulses),
    .gain         (gain),
    .delay_len    (delay_len),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
`ifdef PEDAL_SCHED_STATUS_EN
    ,
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int en_cnt = 0;
  int out_cnt = 0;
  logic [9:0] last_rd = '0;

  typedef struct {
    logic signed [15:0] d;
    int                 due;
  } exp_t;
  exp_t exp_q[$];

  bit signed [15:0] sram [1024];
  bit signed [15:0] ref_mem [1024];
  int ref_ptr = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        sram[mem_addr] <= mem_wdata;
        we_cnt         <= we_cnt + 1;
      end else begin
        mem_rdata <= sram[mem_addr];
        last_rd   <= mem_addr;
      end
    end
  end

  // Output monitor: pop the scoreboard on every out_valid.
  always @(negedge clk) begin
    if (out_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample_out", $signed(sample_out), e.d);
        check("latency", cyc, e.due);
      end
    end
  end

  // Reference model for one accepted sample, applied to ref_mem/ref_ptr.
  task automatic model(input logic signed [15:0] s, output logic signed [15:0] y, output int n);
    int acc, w, d, rd;
    n = delay_reverb ? ((impulses > 8) ? 8 : int'(impulses)) : 1;
    d = (delay_len == 0) ? 1 : int'(delay_len);
    if (record) ref_mem[ref_ptr] = s;
    acc = int'(s);
    w   = int'(gain);
    for (int k = 1; k <= n; k++) begin
      rd  = int'(ref_mem[(ref_ptr - k * d) & 1023]);
      acc = acc + ((rd * w) >>> 8);
      w   = (w * int'(gain)) >> 8;
    end
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    y = 16'(acc);
    if (record) ref_ptr = (ref_ptr + 1) & 1023;
  endtask

  task automatic send(input logic signed [15:0] s, input bit expect_out, input int gap);
    logic signed [15:0] y;
    int n;
    exp_t e;
    @(posedge clk); #1;
    sample_in    = s;
    sample_valid = 1'b1;
    if (expect_out) begin
      model(s, y, n);
      e.d   = y;
      e.due = cyc + n + 3;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic cfg(input logic r, input logic dr, input logic [7:0] imp, input logic [7:0] g, input logic [9:0] dl);
    record = r; delay_reverb = dr; impulses = imp; gain = g; delay_len = dl;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int we0, oc0, en0;
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    cfg(1'b1, 1'b0, 8'd0, 8'd128, 10'd4);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_overrun", overrun, 0);
`ifdef PEDAL_SCHED_STATUS_EN
    check("rst_busy", busy, 0);
    check("rst_overrun_cnt", overrun_cnt, 0);
`endif
    rst = 1'b0;
    ref_ptr = 0;

    // 1: single echo, gain 0.5, 4-sample delay
    send(16'sd1000, 1, 18);
    for (int i = 0; i < 4; i++) send(16'sd0, 1, 18);
    wait_drain();

    // 2: three-tap reverb with an impulse
    do_reset();
    cfg(1'b1, 1'b1, 8'd3, 8'd255, 10'd2);
    send(16'sd8192, 1, 18);
    for (int i = 0; i < 7; i++) send(16'sd0, 1, 18);
    wait_drain();
    // impulses above MAX_TAPS clamp; zero impulses is dry bypass
    cfg(1'b1, 1'b1, 8'd20, 8'd200, 10'd1);
    send(-16'sd1500, 1, 18);
    cfg(1'b1, 1'b1, 8'd0, 8'd200, 10'd0);
    en0 = en_cnt;
    send(16'sd777, 1, 18);
    check("bypass_mem_accesses", en_cnt - en0, 1);
    wait_drain();

    // 3: saturation both ways
    cfg(1'b1, 1'b0, 8'd0, 8'd255, 10'd1);
    send(16'sd32767, 1, 18);
    send(16'sd32767, 1, 18);
    send(-16'sd32768, 1, 18);
    send(-16'sd32768, 1, 18);
    wait_drain();

    // 4: frozen buffer playback
    cfg(1'b1, 1'b0, 8'd0, 8'd100, 10'd1);
    send(16'sd100, 1, 18);
    send(16'sd200, 1, 18);
    send(-16'sd300, 1, 18);
    send(16'sd400, 1, 18);
    wait_drain();
    cfg(1'b0, 1'b1, 8'd4, 8'd200, 10'd1);
    we0 = we_cnt;
    for (int i = 0; i < 3; i++) send(16'sd50, 1, 18);
    wait_drain();
    check("frozen_mem_we", we_cnt - we0, 0);

    // 5: overrun on a strobe two cycles after an accepted one
    cfg(1'b1, 1'b0, 8'd0, 8'd128, 10'd4);
    check("pre_overrun", overrun, 0);
    oc0 = out_cnt;
    send(16'sd1234, 1, 0);
    @(posedge clk); #1;
`ifdef PEDAL_SCHED_STATUS_EN
    check("busy_mid_seq", busy, 1);
`endif
    sample_in = 16'sd999; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("overrun_flag", overrun, 1);
    check("single_out_valid", out_cnt - oc0, 1);
`ifdef PEDAL_SCHED_STATUS_EN
    check("overrun_cnt", overrun_cnt, 1);
`endif
    wait_drain();

    // 6: wrapping tap address, then reset mid-READ
    do_reset();
    check("overrun_cleared", overrun, 0);
    cfg(1'b1, 1'b0, 8'd0, 8'd128, 10'd1);
    send(16'sd10, 1, 18);
    cfg(1'b1, 1'b0, 8'd0, 8'd128, 10'd3);
    send(16'sd20, 1, 18);
    wait_drain();
    check("wrap_tap_addr", last_rd, 1022);
    cfg(1'b0, 1'b1, 8'd8, 8'd200, 10'd1);
    send(16'sd5000, 0, 0);
    @(posedge clk); #1;
    check("in_read_mem_en", mem_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
    check("abort_mem_en", mem_en, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sample_out", sample_out, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    en0 = en_cnt;
    oc0 = out_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_mem_en", en_cnt - en0, 0);
    check("abort_no_output", out_cnt - oc0, 0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
